led_fade_engine: RTL and testbench

- Multi-channel LED breathing controller: one fade engine ramps a shared brightness level 0 -> max -> 0.
- Level steps on a programmable step tick.
- Level drives CH masked PWM outputs sharing one free-running PWM counter.
- Sits between the LED animation sequencer (start/stop, config) and the LED pins; adds one-shot/repeat modes and graceful stop.

---
 rtl/led_fade_engine_if.sv | 46 ++++
 rtl/led_fade_engine.sv | 186 ++++++++++++++++++
 tb/tb_led_fade_engine.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_fade_engine_if.sv
// ---------------------------------------------------------------------------
// led_fade_engine_if
// Bundle between the LED animation sequencer and the fade engine.
//   master modport : sequencer side (drives requests/config, reads status)
//   slave modport  : fade engine side
// Signals:
//   start, stop    single-cycle requests
//   repeat_en      1 = breathe continuously, 0 = one breath (sampled at start)
//   ch_mask        per-channel enable (sampled at start)
//   max_level      peak level (sampled at start)
//   step_div       clk cycles per level step, 0 behaves as 1 (sampled at start)
//   hold_steps     step ticks held at the peak (sampled at start)
//   pwm_out        PWM outputs, one per channel
//   level          current brightness level
//   busy           engine is not idle
//   peak           one-cycle pulse when the peak level is reached
//   done           one-cycle pulse on return to idle
// ---------------------------------------------------------------------------
interface led_fade_engine_if #(
    parameter int CH     = 4,
    parameter int PWM_W  = 8,
    parameter int STEP_W = 16
);
    logic              start;
    logic              stop;
    logic              repeat_en;
    logic [CH-1:0]     ch_mask;
    logic [PWM_W-1:0]  max_level;
    logic [STEP_W-1:0] step_div;
    logic [STEP_W-1:0] hold_steps;
    logic [CH-1:0]     pwm_out;
    logic [PWM_W-1:0]  level;
    logic              busy;
    logic              peak;
    logic              done;

    modport master (
        output start, stop, repeat_en, ch_mask, max_level, step_div, hold_steps,
        input  pwm_out, level, busy, peak, done
    );

    modport slave (
        input  start, stop, repeat_en, ch_mask, max_level, step_div, hold_steps,
        output pwm_out, level, busy, peak, done
    );
endinterface

// File: rtl/led_fade_engine.sv
// ---------------------------------------------------------------------------
// led_fade_engine
// Multi-channel LED breathing controller. A single fade engine ramps a shared
// level 0 -> max -> 0 on a programmable step tick, and the level drives CH
// masked PWM outputs that share one free-running PWM counter.
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   led_fade_engine_if.slave (requests, config, PWM outputs, status)
// Optional build macro:
//   LED_FADE_GAMMA_EN  when defined, duty = (level*level) >> PWM_W giving a
//                      perceptual curve; otherwise duty = level. Level and FSM
//                      timing are identical in both builds.
// ---------------------------------------------------------------------------
module led_fade_engine #(
    parameter int CH     = 4,
    parameter int PWM_W  = 8,
    parameter int STEP_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    led_fade_engine_if.slave    bus
);
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0]  PWM_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN} state_t;

    state_t            r_state;
    logic [PWM_W-1:0]  r_level;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [CH-1:0]     r_pwm_out;
    logic [STEP_W-1:0] r_step_cnt;
    logic [STEP_W-1:0] r_hold_cnt;
    logic              r_repeat;
    logic [CH-1:0]     r_ch_mask;
    logic [PWM_W-1:0]  r_max_level;
    logic [STEP_W-1:0] r_step_div;
    logic [STEP_W-1:0] r_hold_steps;
    logic              r_stop_pending;
    logic              r_busy;
    logic              r_peak;
    logic              r_done;

    logic [STEP_W-1:0] w_div_eff;
    logic              w_tick;
    logic              w_stop_now;
    logic [PWM_W-1:0]  w_lvl_up;
    logic [PWM_W-1:0]  w_lvl_dn;
    logic [PWM_W-1:0]  w_duty;
    logic [CH-1:0]     w_pwm_next;

    // A divider of 0 behaves as 1 so the engine always makes progress.
    assign w_div_eff  = (r_step_div == '0) ? STEP_ONE : r_step_div;
    assign w_tick     = (r_state != IDLE) && (r_step_cnt == (w_div_eff - STEP_ONE));
    // A stop arriving on the very cycle of the final down step still counts.
    assign w_stop_now = r_stop_pending | bus.stop;
    assign w_lvl_up   = r_level + PWM_ONE;
    assign w_lvl_dn   = (r_level != '0) ? (r_level - PWM_ONE) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_level        <= '0;
            r_step_cnt     <= '0;
            r_hold_cnt     <= '0;
            r_repeat       <= 1'b0;
            r_ch_mask      <= '0;
            r_max_level    <= '0;
            r_step_div     <= '0;
            r_hold_steps   <= '0;
            r_stop_pending <= 1'b0;
            r_busy         <= 1'b0;
            r_peak         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_peak <= 1'b0;
            r_done <= 1'b0;
            if (r_state != IDLE) begin
                r_step_cnt <= w_tick ? '0 : (r_step_cnt + STEP_ONE);
                if (bus.stop) begin
                    r_stop_pending <= 1'b1;
                end
            end
            // Branches below that change state also clear the step counter,
            // overriding the free count above.
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_repeat       <= bus.repeat_en;
                        r_ch_mask      <= bus.ch_mask;
                        r_max_level    <= bus.max_level;
                        r_step_div     <= bus.step_div;
                        r_hold_steps   <= bus.hold_steps;
                        r_level        <= '0;
                        r_stop_pending <= 1'b0;
                        r_step_cnt     <= '0;
                        r_hold_cnt     <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (w_tick) begin
                        if (r_level < r_max_level) begin
                            r_level <= w_lvl_up;
                        end
                        // level never exceeds max, so "not below" means the
                        // max_level == 0 case
                        if ((r_level >= r_max_level) || (w_lvl_up == r_max_level)) begin
                            r_peak     <= 1'b1;
                            r_step_cnt <= '0;
                            r_hold_cnt <= '0;
                            r_state    <= HOLD_HI;
                        end
                    end
                end
                HOLD_HI: begin
                    if (r_hold_steps == '0) begin
                        r_step_cnt <= '0;
                        r_state    <= RAMP_DOWN;
                    end else if (w_tick) begin
                        if (r_hold_cnt == (r_hold_steps - STEP_ONE)) begin
                            r_step_cnt <= '0;
                            r_state    <= RAMP_DOWN;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + STEP_ONE;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (w_tick) begin
                        r_level <= w_lvl_dn;
                        if (w_lvl_dn == '0) begin
                            r_step_cnt <= '0;
                            if (r_repeat && !w_stop_now) begin
                                r_state <= RAMP_UP;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_W-1:0] w_lvl_ext;
    logic [2*PWM_W-1:0] w_sq;
    assign w_lvl_ext = {{PWM_W{1'b0}}, r_level};
    assign w_sq      = w_lvl_ext * w_lvl_ext;
    assign w_duty    = PWM_W'(w_sq >> PWM_W);
`else
    assign w_duty = r_level;
`endif

    // Counter values 0..duty-1 drive high, so duty 0 is constant low.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_pwm
            assign w_pwm_next[gi] = r_ch_mask[gi] & (r_pwm_cnt < w_duty);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_pwm_out <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            r_pwm_out <= w_pwm_next;
        end
    end

    assign bus.pwm_out = r_pwm_out;
    assign bus.level   = r_level;
    assign bus.busy    = r_busy;
    assign bus.peak    = r_peak;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_led_fade_engine.sv
// ---------------------------------------------------------------------------
// tb_led_fade_engine
// Self-checking bench for led_fade_engine. A reference model turns each
// configuration into the expected per-cycle trace of level/busy/peak/done,
// and PWM outputs are predicted from the previous cycle's level and a cycle
// count since reset.
// ---------------------------------------------------------------------------
module tb_led_fade_engine;
    localparam int CH     = 4;
    localparam int PWM_W  = 8;
    localparam int STEP_W = 16;
    localparam int PERIOD = 1 << PWM_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    led_fade_engine_if #(.CH(CH), .PWM_W(PWM_W), .STEP_W(STEP_W)) bus ();

    led_fade_engine #(.CH(CH), .PWM_W(PWM_W), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // clk cycles elapsed since reset, modulo the PWM period
    int tb_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt + 1) % PERIOD;
    end

    typedef struct {
        int lvl;
        bit busy;
        bit peak;
        bit done;
    } ent_t;

    ent_t tr[$];
    int   bst[$];

    function automatic int duty_of(int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l) / PERIOD;
`else
        return l;
`endif
    endfunction

    function automatic void push_n(int n, int l, bit pk_first);
        for (int j = 0; j < n; j++) begin
            ent_t e;
            e.lvl  = l;
            e.busy = 1'b1;
            e.peak = pk_first && (j == 0);
            e.done = 1'b0;
            tr.push_back(e);
        end
    endfunction

    // Expected samples taken after each clock edge, starting with the edge
    // that accepts start: every level is held for one step period going up,
    // the peak is held hold*period cycles (one cycle when hold is 0), then
    // every level down to 1 is held one period, and the final sample is idle.
    function automatic void build(int mx, int dv, int hd, int nb);
        int de;
        ent_t e;
        de = (dv == 0) ? 1 : dv;
        tr.delete();
        bst.delete();
        for (int b = 0; b < nb; b++) begin
            bst.push_back(tr.size());
            if (mx == 0) push_n(de, 0, 1'b0);
            else for (int v = 0; v < mx; v++) push_n(de, v, 1'b0);
            push_n((hd == 0) ? 1 : hd * de, mx, 1'b1);
            if (mx == 0) push_n(de, 0, 1'b0);
            else for (int v = mx; v >= 1; v--) push_n(de, v, 1'b0);
        end
        e.lvl = 0; e.busy = 1'b0; e.peak = 1'b0; e.done = 1'b1;
        tr.push_back(e);
    endfunction

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.repeat_en  = 1'b0;
        bus.ch_mask    = '0;
        bus.max_level  = '0;
        bus.step_div   = '0;
        bus.hold_steps = '0;
    endtask

    // Runs one start-to-idle transaction, comparing every cycle with the model.
    // stop_breath >= 0 pulses stop early in that breath; ign_k >= 0 issues a
    // second start plus altered config at that sample; sws pulses stop
    // together with the accepted start.
    task automatic run_trace(input string name, input int mx, input int dv, input int hd,
                             input bit rp, input logic [CH-1:0] mk, input int nb,
                             input int stop_breath, input int ign_k, input bit sws,
                             output int peaks);
        int stop_k, cnt_s, lvl_s, bad0, l, d;
        ent_t e;
        logic [CH-1:0] epwm;
        logic [PWM_W+3+CH-1:0] got, expv;
        build(mx, dv, hd, nb);
        stop_k = (stop_breath >= 0) ? bst[stop_breath] + 1 : -1;
        peaks = 0;
        bad0  = n_bad;
        bus.max_level  = mx[PWM_W-1:0];
        bus.step_div   = dv[STEP_W-1:0];
        bus.hold_steps = hd[STEP_W-1:0];
        bus.repeat_en  = rp;
        bus.ch_mask    = mk;
        bus.stop       = sws;
        bus.start      = 1'b1;
        cnt_s = tb_cnt;
        lvl_s = 0;
        for (int k = 0; k <= tr.size(); k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (k < tr.size()) e = tr[k];
            else begin
                e.lvl = 0; e.busy = 1'b0; e.peak = 1'b0; e.done = 1'b0;
            end
            l = e.lvl;
            d = duty_of(lvl_s);
            for (int i = 0; i < CH; i++) epwm[i] = mk[i] && (cnt_s < d);
            expv = {l[PWM_W-1:0], e.busy, e.peak, e.done, epwm};
            got  = {bus.level, bus.busy, bus.peak, bus.done, bus.pwm_out};
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got lvl=%0d busy=%b peak=%b done=%b pwm=%b, need lvl=%0d busy=%b peak=%b done=%b pwm=%b",
                         name, k, bus.level, bus.busy, bus.peak, bus.done, bus.pwm_out,
                         l, e.busy, e.peak, e.done, epwm);
            end
            if (bus.peak === 1'b1) peaks++;
            cnt_s = tb_cnt;
            lvl_s = l;
            if (k == stop_k) bus.stop = 1'b1;
            if (k == ign_k) begin
                bus.start      = 1'b1;
                bus.max_level  = ~mx[PWM_W-1:0];
                bus.step_div   = dv[STEP_W-1:0] + 16'd5;
                bus.hold_steps = hd[STEP_W-1:0] + 16'd7;
                bus.repeat_en  = ~rp;
                bus.ch_mask    = ~mk;
            end
        end
        $display("run %s max=%0d div=%0d hold=%0d rpt=%0d mask=%b samples=%0d peaks=%0d errs=%0d",
                 name, mx, dv, hd, rp, mk, tr.size() + 1, peaks, n_bad - bad0);
        idle_inputs();
    endtask

    task automatic check_peaks(input string name, input int got, input int need);
        n_cmp++;
        if (got != need) begin
            n_bad++;
            $display("FAIL %s peaks: got %0d need %0d", name, got, need);
        end
    endtask

    task automatic test_reset();
        logic [PWM_W+3+CH-1:0] got;
        bit found, seen;
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        got = {bus.level, bus.busy, bus.peak, bus.done, bus.pwm_out};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %b need all zero", got);
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        // get to level 5 mid ramp-up, then reset between edges
        bus.max_level = 8'd10; bus.step_div = 16'd2; bus.hold_steps = 16'd1;
        bus.ch_mask = 4'b1111; bus.start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.level == 8'd5) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL reset_reach_lvl5: got level %0d need 5 within 60 cycles", bus.level);
        end
        #2 rst = 1'b1;
        #1;
        got = {bus.level, bus.busy, bus.peak, bus.done, bus.pwm_out};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_midrun: got %b need all zero", got);
        end
        idle_inputs();
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_no_done: got done/busy activity after reset, need none");
        end
        $display("run reset done");
    endtask

    task automatic test_one_shot();
        int pk;
        run_trace("one_shot", 4, 3, 2, 1'b0, 4'b0101, 1, -1, -1, 1'b0, pk);
        check_peaks("one_shot", pk, 1);
    endtask

    task automatic test_duty();
        logic [CH-1:0] mk;
        int cnt [CH];
        int need;
        bit found;
        mk = 4'b1011;
        bus.max_level = 8'd64; bus.step_div = 16'd1; bus.hold_steps = 16'd400;
        bus.repeat_en = 1'b0; bus.ch_mask = mk; bus.start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.peak === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL duty_peak: got no peak need one within 300 cycles");
        end
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        for (int c = 0; c < PERIOD; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < CH; i++) if (bus.pwm_out[i] === 1'b1) cnt[i]++;
        end
        for (int i = 0; i < CH; i++) begin
            need = mk[i] ? duty_of(64) : 0;
            n_cmp++;
            if (cnt[i] != need) begin
                n_bad++;
                $display("FAIL duty_ch%0d: got %0d high cycles need %0d", i, cnt[i], need);
            end
        end
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b0) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL duty_finish: got busy still high need idle within 1000 cycles");
        end
        $display("run duty level=64 counts=%0d/%0d/%0d/%0d of %0d", cnt[0], cnt[1], cnt[2], cnt[3], PERIOD);
        idle_inputs();
    endtask

    task automatic test_repeat_stop();
        int pk;
        run_trace("repeat_stop", 3, 1, 0, 1'b1, 4'b1111, 3, 2, -1, 1'b0, pk);
        check_peaks("repeat_stop", pk, 3);
    endtask

    task automatic test_corner();
        int pk;
        run_trace("corner", 0, 0, 0, 1'b0, 4'b1111, 1, -1, -1, 1'b0, pk);
        check_peaks("corner", pk, 1);
    endtask

    task automatic test_ignored();
        int pk;
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_in_idle: got busy=%b need 0", bus.busy);
        end
        run_trace("ignored", 5, 2, 1, 1'b1, 4'b0011, 2, 1, 4, 1'b0, pk);
        check_peaks("ignored", pk, 2);
        run_trace("start_stop", 2, 1, 0, 1'b1, 4'b1100, 2, 1, -1, 1'b1, pk);
        check_peaks("start_stop", pk, 2);
    endtask

    task automatic test_random();
        int pk, mx, dv, hd, nb;
        bit rp;
        logic [CH-1:0] mk;
        for (int n = 0; n < 6; n++) begin
            mx = int'($urandom_range(0, 6));
            dv = int'($urandom_range(0, 3));
            hd = int'($urandom_range(0, 3));
            rp = 1'($urandom_range(0, 1));
            mk = CH'($urandom);
            nb = rp ? 2 : 1;
            run_trace("random", mx, dv, hd, rp, mk, nb, rp ? 1 : -1, -1, 1'b0, pk);
            check_peaks("random", pk, nb);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_duty();
        test_repeat_stop();
        test_corner();
        test_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
